// File: rtl/ucie_ctl_pkg.sv
// rtl/ucie_ctl_pkg.sv - shared types and constants for the UCIe adapter RDI TX endpoint
package ucie_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        FLUSH  = 2'b11
    } adapter_tx_states_e;

    localparam int FLIT_CNT_W = 16;

endpackage

// File: rtl/ucie_ctl_sync_fifo.sv
// rtl/ucie_ctl_sync_fifo.sv - single-clock FIFO with clear, head peek and occupancy count
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_push/i_data write i_data when not full
//   i_pop         drop the head entry when not empty
//   i_clear       discard all entries (wins over push/pop)
//   o_full/o_empty occupancy flags; o_head is the oldest entry; o_count is the occupancy
module ucie_ctl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/ucie_ctl_adapter_rdi_tx.sv
// rtl/ucie_ctl_adapter_rdi_tx.sv - adapter-side RDI data endpoint: TX flit buffer toward the PHY and registered RX path
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_enable                          link Active from the adapter LSM; 0 idles and flushes
//   i_tx_valid/i_tx_data/o_tx_ready   flits from the adapter core
//   o_rdi_lp_irdy/valid/data, i_rdi_pl_trdy   TX toward the PHY
//   i_rdi_pl_valid/i_rdi_pl_data      RX from the PHY
//   o_rx_valid/o_rx_data              RX toward the core, one cycle later, no back-pressure
//   o_tx_flush                        one-cycle pulse when queued flits are discarded
//   o_tx_flit_cnt/o_rx_flit_cnt       saturating flit counters, present only with
//                                     UCIE_CTL_ADAPTER_FLIT_CNT_EN defined
`ifndef NBYTES
`define NBYTES 8
`endif

module ucie_ctl_adapter_rdi_tx
    import ucie_ctl_pkg::*;
#(
    parameter int NBYTES     = `NBYTES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_tx_valid,
    input  logic [NBYTES*8-1:0]   i_tx_data,
    output logic                  o_tx_ready,
    output logic                  o_rdi_lp_irdy,
    output logic                  o_rdi_lp_valid,
    output logic [NBYTES*8-1:0]   o_rdi_lp_data,
    input  logic                  i_rdi_pl_trdy,
    input  logic                  i_rdi_pl_valid,
    input  logic [NBYTES*8-1:0]   i_rdi_pl_data,
    output logic                  o_rx_valid,
    output logic [NBYTES*8-1:0]   o_rx_data,
    output logic                  o_tx_flush
`ifdef UCIE_CTL_ADAPTER_FLIT_CNT_EN
   ,output logic [FLIT_CNT_W-1:0] o_tx_flit_cnt,
    output logic [FLIT_CNT_W-1:0] o_rx_flit_cnt
`endif
);

    localparam int W  = NBYTES * 8;
    localparam int AW = $clog2(FIFO_DEPTH);

    adapter_tx_states_e r_state;
    adapter_tx_states_e w_next;

    logic          w_full;
    logic          w_empty;
    logic [W-1:0]  w_head;
    logic [AW:0]   w_count;
    logic          w_push;
    logic          w_pop;
    logic          w_clear;
    logic          r_rx_valid;
    logic [W-1:0]  r_rx_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        o_tx_ready     = 1'b0;
        o_rdi_lp_irdy  = 1'b0;
        o_rdi_lp_valid = 1'b0;
        o_rdi_lp_data  = '0;
        o_tx_flush     = 1'b0;
        w_clear        = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable) begin
                    w_next = ACTIVE;
                end
            end
            ACTIVE: begin
                o_tx_ready     = !w_full;
                o_rdi_lp_irdy  = !w_empty;
                o_rdi_lp_valid = !w_empty;
                o_rdi_lp_data  = w_empty ? '0 : w_head;
                // Flush decision uses occupancy at the start of the cycle,
                // so a flit popped in the same cycle still triggers FLUSH.
                if (!i_enable) begin
                    w_next = (w_count != '0) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                o_tx_flush = 1'b1;
                w_clear    = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_push = i_tx_valid && o_tx_ready;
    assign w_pop  = o_rdi_lp_valid && i_rdi_pl_trdy;

    ucie_ctl_sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_tx_data),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= (r_state == ACTIVE) && i_rdi_pl_valid;
            r_rx_data  <= i_rdi_pl_valid ? i_rdi_pl_data : '0;
        end
    end

    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;

`ifdef UCIE_CTL_ADAPTER_FLIT_CNT_EN
    logic [FLIT_CNT_W-1:0] r_tx_flit_cnt;
    logic [FLIT_CNT_W-1:0] r_rx_flit_cnt;

    // Counters survive FLUSH; only reset clears them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_flit_cnt <= '0;
            r_rx_flit_cnt <= '0;
        end else begin
            if (w_pop && (r_tx_flit_cnt != '1)) begin
                r_tx_flit_cnt <= r_tx_flit_cnt + FLIT_CNT_W'(1);
            end
            if (r_rx_valid && (r_rx_flit_cnt != '1)) begin
                r_rx_flit_cnt <= r_rx_flit_cnt + FLIT_CNT_W'(1);
            end
        end
    end

    assign o_tx_flit_cnt = r_tx_flit_cnt;
    assign o_rx_flit_cnt = r_rx_flit_cnt;
`endif

endmodule

// File: tb/tb_ucie_ctl_adapter_rdi_tx.sv
// tb/tb_ucie_ctl_adapter_rdi_tx.sv - self-checking bench for ucie_ctl_adapter_rdi_tx
module tb_ucie_ctl_adapter_rdi_tx;

    localparam int W = 64;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         txv = 1'b0;
    logic [W-1:0] txd = '0;
    logic         trdy = 1'b0;
    logic         plv = 1'b0;
    logic [W-1:0] pld = '0;

    logic         tx_ready;
    logic         lp_irdy;
    logic         lp_valid;
    logic [W-1:0] lp_data;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         tx_flush;
`ifdef UCIE_CTL_ADAPTER_FLIT_CNT_EN
    logic [15:0]  tx_cnt;
    logic [15:0]  rx_cnt;
`endif

    ucie_ctl_adapter_rdi_tx #(
        .NBYTES     (8),
        .FIFO_DEPTH (D)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (en),
        .i_tx_valid     (txv),
        .i_tx_data      (txd),
        .o_tx_ready     (tx_ready),
        .o_rdi_lp_irdy  (lp_irdy),
        .o_rdi_lp_valid (lp_valid),
        .o_rdi_lp_data  (lp_data),
        .i_rdi_pl_trdy  (trdy),
        .i_rdi_pl_valid (plv),
        .i_rdi_pl_data  (pld),
        .o_rx_valid     (rx_valid),
        .o_rx_data      (rx_data),
        .o_tx_flush     (tx_flush)
`ifdef UCIE_CTL_ADAPTER_FLIT_CNT_EN
       ,.o_tx_flit_cnt  (tx_cnt),
        .o_rx_flit_cnt  (rx_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: a flit queue, link on/off, a pending-flush flag,
    // the one-cycle RX register and the two saturating counters.
    logic [W-1:0] q[$];
    bit           m_on = 0;
    bit           m_flushing = 0;
    bit           e_rxv = 0;
    logic [W-1:0] e_rxd = '0;
    logic [15:0]  m_txc = '0;
    logic [15:0]  m_rxc = '0;

    initial begin
        bit           a;
        bit           rdy;
        bit           lpv;
        bit           pop;
        bit           push;
        int           sz;
        @(posedge clk);
        forever begin
            @(negedge clk);
            a   = m_on && !m_flushing;
            sz  = q.size();
            rdy = a && (sz < D);
            lpv = a && (sz > 0);
            chk("m_tx_ready", {63'd0, tx_ready}, {63'd0, rdy});
            chk("m_lp_irdy",  {63'd0, lp_irdy},  {63'd0, lpv});
            chk("m_lp_valid", {63'd0, lp_valid}, {63'd0, lpv});
            chk("m_lp_data",  lp_data, lpv ? q[0] : 64'd0);
            chk("m_tx_flush", {63'd0, tx_flush}, {63'd0, m_flushing});
            chk("m_rx_valid", {63'd0, rx_valid}, {63'd0, e_rxv});
            chk("m_rx_data",  rx_data, e_rxd);
`ifdef UCIE_CTL_ADAPTER_FLIT_CNT_EN
            chk("m_tx_cnt", {48'd0, tx_cnt}, {48'd0, m_txc});
            chk("m_rx_cnt", {48'd0, rx_cnt}, {48'd0, m_rxc});
`endif
            if (rst) begin
                q.delete();
                m_on = 0;
                m_flushing = 0;
                e_rxv = 0;
                e_rxd = '0;
                m_txc = '0;
                m_rxc = '0;
            end else begin
                pop  = lpv && trdy;
                push = txv && rdy;
                if (pop && m_txc != 16'hFFFF) m_txc = m_txc + 16'd1;
                if (e_rxv && m_rxc != 16'hFFFF) m_rxc = m_rxc + 16'd1;
                e_rxv = a && plv;
                e_rxd = plv ? pld : '0;
                if (m_flushing) begin
                    q.delete();
                    m_flushing = 0;
                    m_on = 0;
                end else if (m_on) begin
                    if (pop) void'(q.pop_front());
                    if (push) q.push_back(txd);
                    if (!en) begin
                        if (sz > 0) m_flushing = 1;
                        else m_on = 0;
                    end
                end else if (en) begin
                    m_on = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] a_flit [4];
        a_flit[0] = 64'hA1A1_0000_0000_00A1;
        a_flit[1] = 64'hA2A2_0000_0000_00A2;
        a_flit[2] = 64'hA3A3_0000_0000_00A3;
        a_flit[3] = 64'hA4A4_0000_0000_00A4;

        // Reset with enable held high
        en  = 1'b1;
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_tx_ready", {63'd0, tx_ready}, 64'd0);
            chk("rst_lp_valid", {63'd0, lp_valid}, 64'd0);
            chk("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
            chk("rst_tx_flush", {63'd0, tx_flush}, 64'd0);
        end
        rst = 1'b0;
        tick();
        chk("active_after_rst", {63'd0, tx_ready}, 64'd1);

        // Back-pressure: four flits queued while the PHY stalls
        trdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            txv = 1'b1;
            txd = a_flit[i];
            tick();
            chk("bp_head", lp_data, 64'hA1A1_0000_0000_00A1);
        end
        chk("bp_full_ready", {63'd0, tx_ready}, 64'd0);
        txv = 1'b0;
        repeat (2) begin
            tick();
            chk("bp_hold_data", lp_data, 64'hA1A1_0000_0000_00A1);
            chk("bp_hold_valid", {63'd0, lp_valid}, 64'd1);
        end
        trdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain", lp_data, a_flit[i]);
            tick();
        end
        chk("bp_empty", {63'd0, lp_valid}, 64'd0);

        // Streaming: each flit shows up the cycle after its push, no gaps
        for (int i = 0; i < 20; i++) begin
            txv = 1'b1;
            txd = 64'd100 + 64'(i);
            tick();
            chk("stream_data", lp_data, 64'd100 + 64'(i));
        end
        txv = 1'b0;
        tick();
        chk("stream_done", {63'd0, lp_valid}, 64'd0);

        // Flush: three flits stuck, enable dropped
        trdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            txv = 1'b1;
            txd = 64'hF0 + 64'(i);
            tick();
        end
        txv = 1'b0;
        en  = 1'b0;
        tick();
        chk("flush_pulse", {63'd0, tx_flush}, 64'd1);
        chk("flush_lp_valid", {63'd0, lp_valid}, 64'd0);
        tick();
        chk("flush_done", {63'd0, tx_flush}, 64'd0);
        chk("idle_lp_valid", {63'd0, lp_valid}, 64'd0);
        en = 1'b1;
        tick();
        chk("reenable_empty", {63'd0, lp_valid}, 64'd0);
        chk("reenable_ready", {63'd0, tx_ready}, 64'd1);
        trdy = 1'b1;

        // RX path
        plv = 1'b1;
        pld = 64'hDEADBEEF_0BADF00D;
        tick();
        chk("rx_valid", {63'd0, rx_valid}, 64'd1);
        chk("rx_data", rx_data, 64'hDEADBEEF_0BADF00D);
        plv = 1'b0;
        pld = '0;
        tick();
        chk("rx_gap", {63'd0, rx_valid}, 64'd0);
        en  = 1'b0;
        plv = 1'b1;
        pld = 64'h1234;
        tick();
        chk("rx_on_enable_fall", {63'd0, rx_valid}, 64'd1);
        chk("rx_on_enable_fall_data", rx_data, 64'h1234);
        tick();
        chk("rx_idle", {63'd0, rx_valid}, 64'd0);
        plv = 1'b0;
        pld = '0;
        en  = 1'b1;
        tick();

`ifdef UCIE_CTL_ADAPTER_FLIT_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        trdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            txv = 1'b1;
            txd = 64'hC0 + 64'(i);
            tick();
        end
        txv = 1'b0;
        repeat (2) tick();
        plv = 1'b1;
        repeat (3) tick();
        plv = 1'b0;
        repeat (2) tick();
        chk("tx_cnt_5", {48'd0, tx_cnt}, 64'd5);
        chk("rx_cnt_3", {48'd0, rx_cnt}, 64'd3);
        dut.r_tx_flit_cnt = 16'hFFFE;
        dut.r_rx_flit_cnt = 16'hFFFE;
        m_txc = 16'hFFFE;
        m_rxc = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            txv = 1'b1;
            plv = 1'b1;
            tick();
        end
        txv = 1'b0;
        plv = 1'b0;
        repeat (3) tick();
        chk("tx_cnt_sat", {48'd0, tx_cnt}, 64'hFFFF);
        chk("rx_cnt_sat", {48'd0, rx_cnt}, 64'hFFFF);
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
